// File: rtl/mdu_pkg.sv
// Shared MDU op codes and default latencies; also consumed by the decoder that builds mdu_ctrl_D.
package mdu_pkg;

    localparam logic [3:0] MDU_NONE  = 4'd0;
    localparam logic [3:0] MDU_MULT  = 4'd1;
    localparam logic [3:0] MDU_MULTU = 4'd2;
    localparam logic [3:0] MDU_DIV   = 4'd3;
    localparam logic [3:0] MDU_DIVU  = 4'd4;
    localparam logic [3:0] MDU_MTHI  = 4'd5;
    localparam logic [3:0] MDU_MTLO  = 4'd6;
    localparam logic [3:0] MDU_MFHI  = 4'd7;
    localparam logic [3:0] MDU_MFLO  = 4'd8;
    localparam logic [3:0] MDU_MADD  = 4'd9;
    localparam logic [3:0] MDU_MADDU = 4'd10;
    localparam logic [3:0] MDU_MSUB  = 4'd11;
    localparam logic [3:0] MDU_MSUBU = 4'd12;

    localparam int MDU_MUL_CYCLES_DEF = 5;
    localparam int MDU_DIV_CYCLES_DEF = 10;

endpackage

// File: rtl/mdu_if.sv
// E-stage MDU bus: operands/control from the pipeline, HI/LO/busy/read data back.
interface mdu_if;
    logic        Req;
    logic        start;
    logic [3:0]  mdu_ctrl;
    logic [31:0] A;
    logic [31:0] B;
    logic        busy;
    logic [31:0] HI;
    logic [31:0] LO;
    logic [31:0] mdu_rd;

    modport master (output Req, start, mdu_ctrl, A, B,
                    input  busy, HI, LO, mdu_rd);
    modport slave  (input  Req, start, mdu_ctrl, A, B,
                    output busy, HI, LO, mdu_rd);
endinterface

// File: rtl/mdu_calc.sv
// Combinational HI/LO result from latched operands, op and current HI/LO.
// Multiply-accumulate ops are decoded only when MDU_MADD_EN is defined.
module mdu_calc
    import mdu_pkg::*;
(
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [31:0] hi,
    input  logic [31:0] lo,
    output logic [31:0] hi_o,
    output logic [31:0] lo_o
);

    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] q_s, r_s, q_u, r_u;
    logic        div_ovf;
    logic [63:0] res;

    // Sign-extending to 64 bits makes the truncated product the exact signed product.
    assign prod_s  = {{32{a[31]}}, a} * {{32{b[31]}}, b};
    assign prod_u  = {32'd0, a} * {32'd0, b};
    assign div_ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    assign q_s     = $signed(a) / $signed(b);
    assign r_s     = $signed(a) % $signed(b);
    assign q_u     = a / b;
    assign r_u     = a % b;

    always_comb begin
        res = {hi, lo};
        case (op)
            MDU_MULT:  res = prod_s;
            MDU_MULTU: res = prod_u;
            MDU_DIV: begin
                if (div_ovf)        res = {32'd0, 32'h8000_0000};
                else if (b != '0)   res = {r_s, q_s};
            end
            MDU_DIVU:  if (b != '0) res = {r_u, q_u};
`ifdef MDU_MADD_EN
            MDU_MADD:  res = {hi, lo} + prod_s;
            MDU_MADDU: res = {hi, lo} + prod_u;
            MDU_MSUB:  res = {hi, lo} - prod_s;
            MDU_MSUBU: res = {hi, lo} - prod_u;
`endif
            default:   res = {hi, lo};
        endcase
    end

    assign hi_o = res[63:32];
    assign lo_o = res[31:0];

endmodule

// File: rtl/mdu_unit.sv
// E-stage multiply/divide unit: owns HI/LO and models mult/div latency with a busy counter.
// Define MDU_MADD_EN to enable madd/maddu/msub/msubu (op codes 9-12).
module mdu_unit
    import mdu_pkg::*;
#(
    parameter int MUL_CYCLES = MDU_MUL_CYCLES_DEF,
    parameter int DIV_CYCLES = MDU_DIV_CYCLES_DEF
) (
    input logic  clk,
    input logic  reset,
    mdu_if.slave bus
);

    localparam int MAX_CYC = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);
    localparam logic [CNT_W-1:0] MUL_LD = CNT_W'(MUL_CYCLES);
    localparam logic [CNT_W-1:0] DIV_LD = CNT_W'(DIV_CYCLES);

    logic             busy_q, busy_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [31:0]      a_q, a_d, b_q, b_d;
    logic [31:0]      hi_q, hi_d, lo_q, lo_d;
    logic [31:0]      calc_hi, calc_lo;
    logic             is_mul, is_div;

    mdu_calc u_calc (
        .op   (op_q),
        .a    (a_q),
        .b    (b_q),
        .hi   (hi_q),
        .lo   (lo_q),
        .hi_o (calc_hi),
        .lo_o (calc_lo)
    );

    always_comb begin
        is_div = (bus.mdu_ctrl == MDU_DIV) || (bus.mdu_ctrl == MDU_DIVU);
        is_mul = (bus.mdu_ctrl == MDU_MULT) || (bus.mdu_ctrl == MDU_MULTU);
`ifdef MDU_MADD_EN
        is_mul = is_mul || (bus.mdu_ctrl >= MDU_MADD && bus.mdu_ctrl <= MDU_MSUBU);
`endif
    end

    always_comb begin
        busy_d = busy_q;
        cnt_d  = cnt_q;
        op_d   = op_q;
        a_d    = a_q;
        b_d    = b_q;
        hi_d   = hi_q;
        lo_d   = lo_q;
        // In-flight ops finish regardless of Req: they belong to an already committed instruction.
        if (busy_q) begin
            if (cnt_q == CNT_W'(1)) begin
                hi_d   = calc_hi;
                lo_d   = calc_lo;
                busy_d = 1'b0;
                cnt_d  = '0;
            end else begin
                cnt_d = cnt_q - CNT_W'(1);
            end
        end else if (!bus.Req) begin
            if (bus.start && (is_mul || is_div)) begin
                busy_d = 1'b1;
                cnt_d  = is_div ? DIV_LD : MUL_LD;
                op_d   = bus.mdu_ctrl;
                a_d    = bus.A;
                b_d    = bus.B;
            end else if (bus.mdu_ctrl == MDU_MTHI) begin
                hi_d = bus.A;
            end else if (bus.mdu_ctrl == MDU_MTLO) begin
                lo_d = bus.A;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
            op_q   <= MDU_NONE;
            a_q    <= '0;
            b_q    <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else begin
            busy_q <= busy_d;
            cnt_q  <= cnt_d;
            op_q   <= op_d;
            a_q    <= a_d;
            b_q    <= b_d;
            hi_q   <= hi_d;
            lo_q   <= lo_d;
        end
    end

    assign bus.busy   = busy_q;
    assign bus.HI     = hi_q;
    assign bus.LO     = lo_q;
    assign bus.mdu_rd = (bus.mdu_ctrl == MDU_MFHI) ? hi_q :
                        (bus.mdu_ctrl == MDU_MFLO) ? lo_q : 32'd0;

endmodule

// File: tb/tb_mdu_unit.sv
// Scoreboard bench for mdu_unit: expected HI/LO queued at issue, popped when busy falls.
module tb_mdu_unit;
    import mdu_pkg::*;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic  clk = 1'b0;
    logic  reset;
    mdu_if bus_if ();

    exp_t        sb[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] m_hi  = '0;
    logic [31:0] m_lo  = '0;

    mdu_unit dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // mode: 0 plain, 1 pulse Req mid-op, 2 attempt mthi mid-op
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] ehi, input logic [31:0] elo,
                          input int lat, input int mode);
        exp_t e;
        int   n;
        bus_if.start    = 1'b1;
        bus_if.mdu_ctrl = op;
        bus_if.A        = a;
        bus_if.B        = b;
        sb.push_back('{hi: ehi, lo: elo});
        @(negedge clk);
        bus_if.start    = 1'b0;
        bus_if.mdu_ctrl = MDU_NONE;
        n = 0;
        while (bus_if.busy && n < 40) begin
            chk({tag, "_hold_hi"}, bus_if.HI, m_hi);
            chk({tag, "_hold_lo"}, bus_if.LO, m_lo);
            if (n == 1 && mode == 1) bus_if.Req = 1'b1;
            if (n == 1 && mode == 2) begin
                bus_if.mdu_ctrl = MDU_MTHI;
                bus_if.A        = 32'hDEAD_0000;
            end
            if (n == 3) begin
                bus_if.Req      = 1'b0;
                bus_if.mdu_ctrl = MDU_NONE;
            end
            @(negedge clk);
            n++;
        end
        bus_if.Req      = 1'b0;
        bus_if.mdu_ctrl = MDU_NONE;
        chk({tag, "_lat"}, n, lat);
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 1, 0);
        end else begin
            e = sb.pop_front();
            chk({tag, "_hi"}, bus_if.HI, e.hi);
            chk({tag, "_lo"}, bus_if.LO, e.lo);
            m_hi = e.hi;
            m_lo = e.lo;
        end
    endtask

    task automatic mt(input logic [3:0] op, input logic [31:0] v);
        bus_if.mdu_ctrl = op;
        bus_if.A        = v;
        @(negedge clk);
        bus_if.mdu_ctrl = MDU_NONE;
        if (op == MDU_MTHI) m_hi = v; else m_lo = v;
    endtask

    initial begin
        longint          sa, sb_, sp;
        longint unsigned ua, ub, up;
        logic [31:0]     ra, rb;

        reset           = 1'b1;
        bus_if.Req      = 1'b0;
        bus_if.start    = 1'b0;
        bus_if.mdu_ctrl = MDU_NONE;
        bus_if.A        = '0;
        bus_if.B        = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_busy", bus_if.busy, 0);
        chk("rst_hi", bus_if.HI, 0);
        chk("rst_lo", bus_if.LO, 0);
        chk("rst_rd", bus_if.mdu_rd, 0);

        mt(MDU_MTHI, 32'h0000_ABCD);
        bus_if.mdu_ctrl = MDU_MFHI; #1;
        chk("mfhi", bus_if.mdu_rd, 32'h0000_ABCD);
        @(negedge clk);
        mt(MDU_MTLO, 32'h1234_5678);
        bus_if.mdu_ctrl = MDU_MFLO; #1;
        chk("mflo", bus_if.mdu_rd, 32'h1234_5678);
        bus_if.mdu_ctrl = MDU_NONE; #1;
        chk("rd_none", bus_if.mdu_rd, 0);
        @(negedge clk);

        run_op("mult", MDU_MULT, 32'hFFFF_FFFE, 32'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 5, 0);
        run_op("divu", MDU_DIVU, 32'd7, 32'd2, 32'd1, 32'd3, 10, 0);
        run_op("div", MDU_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 10, 0);
        mt(MDU_MTHI, 32'h11);
        mt(MDU_MTLO, 32'h22);
        run_op("div0", MDU_DIV, 32'd5, 32'd0, 32'h11, 32'h22, 10, 0);
        run_op("divovf", MDU_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'h8000_0000, 10, 0);

        // Req on the issue edge: nothing issues, nothing is written.
        bus_if.Req = 1'b1; bus_if.start = 1'b1; bus_if.mdu_ctrl = MDU_MULT;
        bus_if.A = 32'd5; bus_if.B = 32'd5;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.mdu_ctrl = MDU_MTHI; bus_if.A = 32'h5555;
        chk("req_busy", bus_if.busy, 0);
        @(negedge clk);
        bus_if.Req = 1'b0; bus_if.mdu_ctrl = MDU_NONE;
        chk("req_busy2", bus_if.busy, 0);
        chk("req_hi", bus_if.HI, m_hi);
        chk("req_lo", bus_if.LO, m_lo);

        run_op("req_mid", MDU_MULT, 32'h0001_0000, 32'h0001_0000, 32'd1, 32'd0, 5, 1);
        run_op("mthi_mid", MDU_MULTU, 32'hFFFF_FFFF, 32'd2, 32'd1, 32'hFFFF_FFFE, 5, 2);

        for (int i = 0; i < 3; i++) begin
            ra = $urandom; rb = $urandom;
            sa = $signed(ra); sb_ = $signed(rb); sp = sa * sb_;
            run_op("rmult", MDU_MULT, ra, rb, sp[63:32], sp[31:0], 5, 0);
            ua = ra; ub = rb; up = ua * ub;
            run_op("rmultu", MDU_MULTU, ra, rb, up[63:32], up[31:0], 5, 0);
        end

        mt(MDU_MTHI, 32'd0);
        mt(MDU_MTLO, 32'hFFFF_FFFF);
`ifdef MDU_MADD_EN
        run_op("maddu", MDU_MADDU, 32'd1, 32'd1, 32'd1, 32'd0, 5, 0);
`else
        bus_if.start = 1'b1; bus_if.mdu_ctrl = MDU_MADDU; bus_if.A = 32'd1; bus_if.B = 32'd1;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.mdu_ctrl = MDU_NONE;
        chk("maddu_off_busy", bus_if.busy, 0);
        @(negedge clk);
        chk("maddu_off_hi", bus_if.HI, 32'd0);
        chk("maddu_off_lo", bus_if.LO, 32'hFFFF_FFFF);
`endif

        // Reset during a divide discards the in-flight result.
        bus_if.start = 1'b1; bus_if.mdu_ctrl = MDU_DIVU; bus_if.A = 32'd100; bus_if.B = 32'd7;
        @(negedge clk);
        bus_if.start = 1'b0; bus_if.mdu_ctrl = MDU_NONE;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstmid_busy", bus_if.busy, 0);
        chk("rstmid_hi", bus_if.HI, 0);
        chk("rstmid_lo", bus_if.LO, 0);
        repeat (12) @(negedge clk);
        chk("rstmid_busy2", bus_if.busy, 0);
        chk("rstmid_hi2", bus_if.HI, 0);
        chk("rstmid_lo2", bus_if.LO, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mdu_unit.md
Name: mdu_unit

Overview:
- Multiply/divide unit in the E stage. Consumes the D->E pipeline register outputs start_E, mdu_ctrl_E and the forwarded RFD1/RFD2 operands.
- Owns the HI/LO registers and models multi-cycle mult/div latency with a busy counter.
- The hazard unit stalls D on (start | busy) whenever the D instruction uses the MDU.
- Exception flush (Req) suppresses new issue.

Parameters:
- MUL_CYCLES, 5, cycles from the start edge until the mult/multu result is visible in HI/LO.
- DIV_CYCLES, 10, cycles from the start edge until the div/divu result is visible in HI/LO.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- Req  input  1  exception/interrupt flush; blocks any issue or HI/LO write from E this cycle.
- start  input  1  E instruction is mult/multu/div/divu (start_E).
- mdu_ctrl  input  4  operation code (mdu_ctrl_E).
- A  input  32  rs operand, already forwarded.
- B  input  32  rt operand, already forwarded.
- busy  output  1  operation in flight.
- HI  output  32  HI register.
- LO  output  32  LO register.
- mdu_rd  output  32  mfhi/mflo read data, combinational.

Behaviour:
- Op codes:
  - 0 none, 1 mult, 2 multu, 3 div, 4 divu
  - 5 mthi, 6 mtlo, 7 mfhi, 8 mflo
  - 9-15 reserved; treated as none.
- Reset (synchronous, highest priority):
  - busy=0, HI=0, LO=0, counter=0, operand latches=0.
  - Applies mid-operation: an in-flight result is discarded.
- Issue: at a posedge with start=1, Req=0, busy=0 and mdu_ctrl in 1..4:
  - latch A, B and the op;
  - load counter with MUL_CYCLES or DIV_CYCLES;
  - busy=1 from the next cycle.
- start with busy=1 is ignored; the hazard unit guarantees this never occurs.
- Counting:
  - while busy, decrement the counter each cycle;
  - when the counter reaches 1, on that edge write HI/LO and clear busy;
  - HI/LO change and busy falls on the same edge.
- Arithmetic:
  - mult: {HI,LO} = signed 64-bit product.
  - multu: {HI,LO} = unsigned 64-bit product.
  - div: LO = signed quotient, HI = signed remainder; remainder takes the sign of the dividend (truncation toward zero).
  - divu: unsigned quotient and remainder.
  - Divide by zero: HI/LO unchanged; busy still runs the full DIV_CYCLES.
  - 0x80000000 / -1 (div): LO=0x80000000, HI=0.
- mthi/mtlo (ctrl 5/6):
  - write HI/LO from A at the next edge when Req=0 and busy=0;
  - ignored when Req=1 or busy=1; the hazard unit stalls these while busy.
- mfhi/mflo: mdu_rd = HI or LO combinationally when ctrl is 7/8, else 0. Reads the current register value (no bypass of a same-edge write).
- Req=1 with start=1 on the same edge: no issue, busy stays 0, HI/LO untouched.
- An operation already in flight when Req rises continues to completion; it belongs to an older, committed instruction.

Optional Feature:
- Macro: MDU_MADD_EN.
- When defined, adds op codes 9 madd, 10 maddu, 11 msub, 12 msubu.
  - Issue and latency are identical to mult.
  - At completion: {HI,LO} = {HI,LO} ± product, signed or unsigned per op, wrapping modulo 2^64.
  - The {HI,LO} value used is the one at completion time.
- When undefined, codes 9-12 are treated as none: no busy, no state change.

Decomposition:
- Shared package mdu_pkg holds:
  - op code constants (MDU_NONE, MDU_MULT ... MDU_MFLO, MDU_MADD ... MDU_MSUBU);
  - default latency constants.
- The same package is used by the controller that generates mdu_ctrl_D.
- One natural sub-module: mdu_calc, purely combinational 64-bit result computation from latched operands, op and current HI/LO. The counter and state stay in mdu_unit.

Test Plan:
- mult A=0xFFFFFFFE(-2), B=3, start 1 cycle -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; HI/LO unchanged before that edge.
- divu A=7, B=2 -> busy for 10 cycles, LO=3, HI=1. div A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- div A=5, B=0 with prior HI=0x11, LO=0x22 -> busy for 10 cycles, then HI=0x11, LO=0x22 unchanged.
- start=1 with Req=1 on the same edge -> busy stays 0, HI/LO unchanged. Req asserted mid-mult -> result still written on schedule.
- reset asserted at cycle 3 of a div -> busy=0, HI=LO=0 the next cycle, no later write. mthi A=0xABCD then mfhi -> mdu_rd=0xABCD on the following cycle.
- With MDU_MADD_EN: HI=0, LO=0xFFFFFFFF, maddu A=1, B=1 -> after 5 cycles HI=1, LO=0. Without the macro: same stimulus -> busy never rises.
